// File: rtl/mib_master_retry.sv
// Cmd-bus to MIB bridge: serialises address/data beats, per-beat ACK timeout, automatic retry.
// Optional statistics counters are enabled with MIB_MASTER_RETRY_STATS_EN.
module mib_master_retry #(
  parameter int P_ADDR_BITS            = 24,
  parameter int P_DATA_BITS            = 32,
  parameter int P_AD_BITS              = 16,
  parameter int P_MIB_ACK_TIMEOUT_CLKS = 32,
  parameter int P_MAX_RETRIES          = 2
) (
  input  logic                   i_sysclk,
  input  logic                   i_rst_n,
`ifdef MIB_MASTER_RETRY_STATS_EN
  output logic [15:0]            o_stat_timeouts,
  output logic [15:0]            o_stat_fails,
`endif
  input  logic                   i_cmd_sel,
  input  logic                   i_cmd_rd_wr_n,
  input  logic [P_ADDR_BITS-1:0] i_cmd_byte_addr,
  input  logic [P_DATA_BITS-1:0] i_cmd_wdata,
  output logic                   o_cmd_ack,
  output logic [P_DATA_BITS-1:0] o_cmd_rdata,
  output logic                   o_cmd_timeout,
  output logic                   o_busy,
  input  logic [P_AD_BITS-1:0]   i_mib_ad,
  input  logic                   i_mib_slave_ack,
  output logic                   o_mib_start,
  output logic                   o_mib_rd_wr_n,
  output logic [P_AD_BITS-1:0]   o_mib_ad,
  output logic                   o_mib_ad_high_z
);

  localparam int ABEATS = (P_ADDR_BITS + P_AD_BITS - 1) / P_AD_BITS;
  localparam int DBEATS = (P_DATA_BITS + P_AD_BITS - 1) / P_AD_BITS;
  localparam int AEXT   = ABEATS * P_AD_BITS;
  localparam int DEXT   = DBEATS * P_AD_BITS;
  localparam int MAXB   = (ABEATS > DBEATS) ? ABEATS : DBEATS;
  localparam int BW     = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TW     = $clog2(P_MIB_ACK_TIMEOUT_CLKS);
  localparam int RW     = (P_MAX_RETRIES > 0) ? $clog2(P_MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_TURN, S_RDATA, S_DONE, S_BACKOFF
  } state_t;

  // Beat b of the zero-extended address, most significant beat first.
  function automatic logic [P_AD_BITS-1:0] addr_beat(input logic [P_ADDR_BITS-1:0] a,
                                                     input logic [BW-1:0] b);
    logic [AEXT-1:0] ext;
    ext = AEXT'(a);
    return P_AD_BITS'(ext >> ((ABEATS - 1 - int'(b)) * P_AD_BITS));
  endfunction

  function automatic logic [P_AD_BITS-1:0] data_beat(input logic [P_DATA_BITS-1:0] d,
                                                     input logic [BW-1:0] b);
    logic [DEXT-1:0] ext;
    ext = DEXT'(d);
    return P_AD_BITS'(ext >> ((DBEATS - 1 - int'(b)) * P_AD_BITS));
  endfunction

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   bo_q, bo_d;
  logic                   fail_q, fail_d;
  logic                   rd_wr_n_q, rd_wr_n_d;
  logic [P_ADDR_BITS-1:0] addr_q, addr_d;
  logic [P_DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DEXT-1:0]        shift_q, shift_d;
  logic                   abort_s;

  logic                   cmd_ack_q, cmd_ack_d;
  logic [P_DATA_BITS-1:0] cmd_rdata_q, cmd_rdata_d;
  logic                   cmd_timeout_q, cmd_timeout_d;
  logic                   busy_q, busy_d;
  logic                   mib_start_q, mib_start_d;
  logic                   mib_rd_wr_n_q, mib_rd_wr_n_d;
  logic [P_AD_BITS-1:0]   mib_ad_q, mib_ad_d;
  logic                   mib_high_z_q, mib_high_z_d;

  // Next-state logic: beat sequencing, ACK timeout and retry decisions.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tcnt_d    = tcnt_q;
    retry_d   = retry_q;
    bo_d      = bo_q;
    fail_d    = fail_q;
    rd_wr_n_d = rd_wr_n_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    abort_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_sel) begin
          rd_wr_n_d = i_cmd_rd_wr_n;
          addr_d    = i_cmd_byte_addr;
          wdata_d   = i_cmd_wdata;
          retry_d   = '0;
          fail_d    = 1'b0;
          beat_d    = '0;
          state_d   = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (beat_q == BW'(ABEATS - 1)) begin
          beat_d  = '0;
          tcnt_d  = '0;
          state_d = rd_wr_n_q ? S_TURN : S_WDATA;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_WDATA, S_RDATA: begin
        // An ACK on the terminal-count clock still completes the beat.
        if (i_mib_slave_ack) begin
          tcnt_d = '0;
          if (state_q == S_RDATA) begin
            shift_d = (shift_q << P_AD_BITS) | DEXT'(i_mib_ad);
          end else begin
            shift_d = shift_q;
          end
          if (beat_q == BW'(DBEATS - 1)) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (tcnt_q == TW'(P_MIB_ACK_TIMEOUT_CLKS - 1)) begin
          abort_s = 1'b1;
          bo_d    = 1'b0;
          state_d = S_BACKOFF;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_TURN: begin
        beat_d  = '0;
        tcnt_d  = '0;
        state_d = S_RDATA;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_BACKOFF: begin
        if (!bo_q) begin
          bo_d = 1'b1;
        end else begin
          bo_d   = 1'b0;
          beat_d = '0;
          if (int'(retry_q) < P_MAX_RETRIES) begin
            retry_d = retry_q + RW'(1);
            state_d = S_ADDR;
          end else begin
            fail_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    cmd_ack_d     = (state_d == S_DONE);
    cmd_timeout_d = (state_d == S_DONE) && fail_d;
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
    mib_start_d   = (state_d == S_ADDR) && (beat_d == '0);
    mib_high_z_d  = !((state_d == S_ADDR) || (state_d == S_WDATA));
    mib_rd_wr_n_d = rd_wr_n_d;
    cmd_rdata_d   = cmd_rdata_q;
    if (state_d == S_DONE) begin
      if (fail_d) begin
        cmd_rdata_d = '0;
      end else if (rd_wr_n_d) begin
        cmd_rdata_d = shift_d[P_DATA_BITS-1:0];
      end else begin
        cmd_rdata_d = cmd_rdata_q;
      end
    end else begin
      cmd_rdata_d = cmd_rdata_q;
    end
    case (state_d)
      S_ADDR:  mib_ad_d = addr_beat(addr_d, beat_d);
      S_WDATA: mib_ad_d = data_beat(wdata_d, beat_d);
      default: mib_ad_d = '0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      tcnt_q        <= '0;
      retry_q       <= '0;
      bo_q          <= 1'b0;
      fail_q        <= 1'b0;
      rd_wr_n_q     <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      shift_q       <= '0;
      cmd_ack_q     <= 1'b0;
      cmd_rdata_q   <= '0;
      cmd_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      mib_start_q   <= 1'b0;
      mib_rd_wr_n_q <= 1'b1;
      mib_ad_q      <= '0;
      mib_high_z_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tcnt_q        <= tcnt_d;
      retry_q       <= retry_d;
      bo_q          <= bo_d;
      fail_q        <= fail_d;
      rd_wr_n_q     <= rd_wr_n_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      shift_q       <= shift_d;
      cmd_ack_q     <= cmd_ack_d;
      cmd_rdata_q   <= cmd_rdata_d;
      cmd_timeout_q <= cmd_timeout_d;
      busy_q        <= busy_d;
      mib_start_q   <= mib_start_d;
      mib_rd_wr_n_q <= mib_rd_wr_n_d;
      mib_ad_q      <= mib_ad_d;
      mib_high_z_q  <= mib_high_z_d;
    end
  end

  assign o_cmd_ack       = cmd_ack_q;
  assign o_cmd_rdata     = cmd_rdata_q;
  assign o_cmd_timeout   = cmd_timeout_q;
  assign o_busy          = busy_q;
  assign o_mib_start     = mib_start_q;
  assign o_mib_rd_wr_n   = mib_rd_wr_n_q;
  assign o_mib_ad        = mib_ad_q;
  assign o_mib_ad_high_z = mib_high_z_q;

`ifdef MIB_MASTER_RETRY_STATS_EN
  logic [15:0] stat_to_q, stat_to_d;
  logic [15:0] stat_fail_q, stat_fail_d;
  logic        fail_evt_s;

  // Saturating counters of aborted attempts and of failed transactions.
  always_comb begin
    fail_evt_s  = (state_q == S_BACKOFF) && (state_d == S_DONE);
    stat_to_d   = stat_to_q;
    stat_fail_d = stat_fail_q;
    if (abort_s && (stat_to_q != 16'hFFFF)) begin
      stat_to_d = stat_to_q + 16'd1;
    end else begin
      stat_to_d = stat_to_q;
    end
    if (fail_evt_s && (stat_fail_q != 16'hFFFF)) begin
      stat_fail_d = stat_fail_q + 16'd1;
    end else begin
      stat_fail_d = stat_fail_q;
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_to_q   <= 16'd0;
      stat_fail_q <= 16'd0;
    end else begin
      stat_to_q   <= stat_to_d;
      stat_fail_q <= stat_fail_d;
    end
  end

  assign o_stat_timeouts = stat_to_q;
  assign o_stat_fails    = stat_fail_q;
`else
  logic unused_abort_s;
  assign unused_abort_s = abort_s;
`endif

endmodule

// File: tb/tb_mib_master_retry.sv
// Randomised self-checking bench for mib_master_retry; the slave and expected
// results come from a beat/cycle-count model of the protocol.
module tb_mib_master_retry;

  localparam int AB   = 2;
  localparam int DB   = 2;
  localparam int TO   = 32;
  localparam int MAXR = 2;

  logic        clk;
  logic        rst_n;
  logic        sel, rd;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic        ack, tout, busy;
  logic [31:0] rdata;
  logic [15:0] mad_in, mad;
  logic        sack, start, mrw, hz;

  logic        n_sel, n_ack, n_tout, n_busy, n_sack, n_start, n_mrw, n_hz;
  logic [31:0] n_rdata;
  logic [7:0]  n_mad_in, n_mad;

  int vectors = 0;
  int errors  = 0;

`ifdef MIB_MASTER_RETRY_STATS_EN
  logic [15:0] st_to, st_fail, n_st_to, n_st_fail;
`endif

  mib_master_retry u_dut (
    .i_sysclk(clk), .i_rst_n(rst_n),
`ifdef MIB_MASTER_RETRY_STATS_EN
    .o_stat_timeouts(st_to), .o_stat_fails(st_fail),
`endif
    .i_cmd_sel(sel), .i_cmd_rd_wr_n(rd), .i_cmd_byte_addr(addr), .i_cmd_wdata(wdata),
    .o_cmd_ack(ack), .o_cmd_rdata(rdata), .o_cmd_timeout(tout), .o_busy(busy),
    .i_mib_ad(mad_in), .i_mib_slave_ack(sack), .o_mib_start(start),
    .o_mib_rd_wr_n(mrw), .o_mib_ad(mad), .o_mib_ad_high_z(hz)
  );

  mib_master_retry #(.P_AD_BITS(8)) u_dut8 (
    .i_sysclk(clk), .i_rst_n(rst_n),
`ifdef MIB_MASTER_RETRY_STATS_EN
    .o_stat_timeouts(n_st_to), .o_stat_fails(n_st_fail),
`endif
    .i_cmd_sel(n_sel), .i_cmd_rd_wr_n(1'b1), .i_cmd_byte_addr(24'h123456), .i_cmd_wdata(32'h0),
    .o_cmd_ack(n_ack), .o_cmd_rdata(n_rdata), .o_cmd_timeout(n_tout), .o_busy(n_busy),
    .i_mib_ad(n_mad_in), .i_mib_slave_ack(n_sack), .o_mib_start(n_start),
    .o_mib_rd_wr_n(n_mrw), .o_mib_ad(n_mad), .o_mib_ad_high_z(n_hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    vectors++;
    if ({ack, tout, busy, start, mrw, hz} !== 6'b000011 || mad !== 16'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got ack/tout/busy/start/rw/hz=%b ad=%h rdata=%h, need 000011 0000 00000000",
               {ack, tout, busy, start, mrw, hz}, mad, rdata);
    end
  endtask

  // One cmd transaction against a modelled slave. The slave stays silent for the
  // first 'silent' attempts, then ACKs each data beat after a random stall.
  task automatic run_txn(input string name, input bit is_rd, input logic [23:0] a,
                         input logic [31:0] wd, input int silent, input int max_stall,
                         input bit force_max, input bit use_fixed, input logic [31:0] fixed_words,
                         input bit extra_sel);
    int attempt, pos, db, w, stall, sum_stall, acks, starts, ack_cycle, exp_cycle, nfail, turn;
    bit live, success, got_to, got_busy;
    logic [31:0] exp_rd, got_rd, aext, wext;
    logic [15:0] word, exp_ad;
    attempt = 0; pos = 0; db = 0; w = 0; stall = 0; sum_stall = 0; acks = 0; starts = 0;
    ack_cycle = -1; live = 1'b0; exp_rd = 32'h0; got_rd = 32'h0; got_to = 1'b0; got_busy = 1'b1;
    aext = {8'h00, a};
    wext = wd;
    turn = is_rd ? 1 : 0;
    @(negedge clk);
    sel = 1'b1; rd = is_rd; addr = a; wdata = wd;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      sel = extra_sel && (c == 3);
      if (c == 3) addr = ~a;
      sack = 1'b0;
      if (ack) begin
        acks++;
        if (acks == 1) begin
          ack_cycle = c; got_rd = rdata; got_to = tout; got_busy = busy;
        end
      end
      if (start) begin
        attempt++; starts++; pos = 0; db = 0; w = 0; live = 1'b1;
        stall = force_max ? TO - 1 : $urandom_range(max_stall, 0);
      end
      if (live) begin
        if (pos < AB) begin
          exp_ad = 16'((aext >> (16 * (AB - 1 - pos))) & 32'hFFFF);
          vectors++;
          if (mad !== exp_ad || hz !== 1'b0 || mrw !== is_rd) begin
            errors++;
            $display("FAIL %s addr_beat%0d: got ad=%h hz=%b rw=%b, need ad=%h hz=0 rw=%b",
                     name, pos, mad, hz, mrw, exp_ad, is_rd);
          end
        end else if (attempt > silent && db < DB && (!is_rd || pos > AB)) begin
          if (w == stall) begin
            sack = 1'b1;
            if (!is_rd) begin
              exp_ad = 16'((wext >> (16 * (DB - 1 - db))) & 32'hFFFF);
              vectors++;
              if (mad !== exp_ad || hz !== 1'b0) begin
                errors++;
                $display("FAIL %s wdata_beat%0d: got ad=%h hz=%b, need ad=%h hz=0", name, db, mad, hz, exp_ad);
              end
            end else begin
              word = use_fixed ? ((db == 0) ? fixed_words[31:16] : fixed_words[15:0]) : 16'($urandom);
              mad_in = word;
              exp_rd = (exp_rd << 16) | {16'h0, word};
              vectors++;
              if (hz !== 1'b1) begin
                errors++;
                $display("FAIL %s rdata_hz%0d: got hz=%b, need 1", name, db, hz);
              end
            end
            sum_stall += stall + 1;
            db++; w = 0;
            stall = force_max ? TO - 1 : $urandom_range(max_stall, 0);
          end else begin
            w++;
          end
        end
        pos++;
      end
      if (acks > 0 && c >= ack_cycle + 4) break;
    end
    sack = 1'b0; sel = 1'b0;
    success = (silent <= MAXR);
    nfail = success ? silent : MAXR + 1;
    exp_cycle = 1 + nfail * (AB + turn + TO + 2) + (success ? AB + turn + sum_stall : 0);
    vectors++;
    if (acks !== 1) begin
      errors++; $display("FAIL %s ack_count: got %0d, need 1", name, acks);
    end
    vectors++;
    if (ack_cycle !== exp_cycle) begin
      errors++; $display("FAIL %s ack_cycle: got %0d, need %0d", name, ack_cycle, exp_cycle);
    end
    vectors++;
    if (got_to !== !success || got_busy !== 1'b0) begin
      errors++; $display("FAIL %s timeout/busy: got %b/%b, need %b/0", name, got_to, got_busy, !success);
    end
    vectors++;
    if (starts !== nfail + (success ? 1 : 0)) begin
      errors++; $display("FAIL %s start_count: got %0d, need %0d", name, starts, nfail + (success ? 1 : 0));
    end
    if (is_rd || !success) begin
      vectors++;
      if (got_rd !== (success ? exp_rd : 32'h0)) begin
        errors++; $display("FAIL %s rdata: got %h, need %h", name, got_rd, success ? exp_rd : 32'h0);
      end
    end
  endtask

  task automatic test_basic();
    run_txn("wr_basic", 1'b0, 24'h000004, 32'h01010202, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_txn("rd_basic", 1'b1, 24'h000004, 32'h0, 0, 0, 1'b0, 1'b1, 32'hCAFEBEEF, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_txn("rand", 1'($urandom), 24'($urandom), $urandom, 0, 10, 1'b0, 1'b0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_ack_on_terminal();
    run_txn("wr_term", 1'b0, 24'hABCDEF, 32'h89ABCDEF, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    run_txn("rd_term", 1'b1, 24'h00FFEE, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_retry();
    run_txn("wr_retry", 1'b0, 24'h102030, 32'hDEADBEEF, 1, 3, 1'b0, 1'b0, 32'h0, 1'b0);
    run_txn("rd_retry2", 1'b1, 24'h405060, 32'h0, 2, 3, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_all_fail();
`ifdef MIB_MASTER_RETRY_STATS_EN
    logic [15:0] to0, f0;
    to0 = st_to; f0 = st_fail;
`endif
    run_txn("wr_fail", 1'b0, 24'h0000AA, 32'h12345678, 3, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_txn("rd_fail", 1'b1, 24'h0000BB, 32'h0, 3, 0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef MIB_MASTER_RETRY_STATS_EN
    vectors++;
    if (st_to !== to0 + 16'd6 || st_fail !== f0 + 16'd2) begin
      errors++;
      $display("FAIL stats: got timeouts=%0d fails=%0d, need %0d %0d", st_to, st_fail, to0 + 16'd6, f0 + 16'd2);
    end
`endif
  endtask

  task automatic test_back_to_back_sel();
    run_txn("wr_busy_sel", 1'b0, 24'h000100, 32'hA5A55A5A, 0, 2, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int late_acks;
    late_acks = 0;
    @(negedge clk);
    sel = 1'b1; rd = 1'b0; addr = 24'h000010; wdata = 32'h11112222;
    @(negedge clk); sel = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (hz !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre: got hz=%b busy=%b, need 0 1", hz, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (hz !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || ack !== 1'b0 || mrw !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got hz/busy/start/ack/rw=%b%b%b%b%b, need 10001", hz, busy, start, ack, mrw);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) late_acks++;
    end
    vectors++;
    if (late_acks !== 0) begin
      errors++; $display("FAIL mid_reset_ack: got %0d acks, need 0", late_acks);
    end
  endtask

  task automatic test_narrow();
    int pos, db, ack_cycle;
    bit live;
    logic [31:0] exp_rd, got_rd, aext;
    logic [7:0] word, exp_ad;
    pos = 0; db = 0; ack_cycle = -1; live = 1'b0; exp_rd = 32'h0; got_rd = 32'h0;
    aext = 32'h00123456;
    @(negedge clk); n_sel = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      n_sel = 1'b0; n_sack = 1'b0;
      if (n_ack && ack_cycle < 0) begin
        ack_cycle = c; got_rd = n_rdata;
      end
      if (n_start) begin
        live = 1'b1; pos = 0;
      end
      if (live) begin
        if (pos < 3) begin
          exp_ad = 8'((aext >> (8 * (2 - pos))) & 32'hFF);
          vectors++;
          if (n_mad !== exp_ad || n_hz !== 1'b0) begin
            errors++; $display("FAIL narrow_addr%0d: got %h hz=%b, need %h hz=0", pos, n_mad, n_hz, exp_ad);
          end
        end else if (pos > 3 && db < 4) begin
          word = 8'($urandom);
          n_mad_in = word; n_sack = 1'b1;
          exp_rd = (exp_rd << 8) | {24'h0, word};
          db++;
        end
        pos++;
      end
      if (ack_cycle > 0) break;
    end
    n_sack = 1'b0;
    vectors++;
    if (ack_cycle !== 9 || got_rd !== exp_rd) begin
      errors++;
      $display("FAIL narrow_read: got cycle %0d rdata %h, need cycle 9 rdata %h", ack_cycle, got_rd, exp_rd);
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; rd = 1'b0; addr = 24'h0; wdata = 32'h0; mad_in = 16'h0; sack = 1'b0;
    n_sel = 1'b0; n_sack = 1'b0; n_mad_in = 8'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_random();
    test_ack_on_terminal();
    test_retry();
    test_all_fail();
    test_back_to_back_sel();
    test_reset_mid();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
